lsu_bus_ctrl: RTL and testbench



---
 rtl/lsu_bus_ctrl.sv | 104 ++++++++++
 tb/tb_lsu_bus_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns one pipeline load or store into a single
// memory-bus transaction, with a bounded wait that ends in an error pulse.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  input  logic        st_req,
  input  logic [15:0] addr,
  input  logic [15:0] st_data,
  output logic        busy,
  output logic [15:0] mem_data,
  output logic        mem_valid,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       accept;

  // Bus handshake: bus_req is held with bus_we/bus_addr/bus_wdata stable until
  // the cycle bus_ack is sampled high (transfer done) or the wait budget runs out;
  // bus_ack seen in any other state is ignored.
  assign accept = (state == S_IDLE) && (ld_req || st_req);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt    = S_REQ;
          wait_cnt_nxt = 4'd0;
        end
      end
      S_REQ: begin
        if (bus_ack) begin
          state_nxt = S_DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
          if (wait_cnt_nxt == TIMEOUT_CNT) state_nxt = S_ERR;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // A simultaneous load and store issues the load; the store is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_we    <= 1'b0;
      bus_addr  <= 16'h0000;
      bus_wdata <= 16'h0000;
    end else if (accept) begin
      bus_we    <= ~ld_req;
      bus_addr  <= addr;
      bus_wdata <= st_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data <= 16'h0000;
    end else if ((state == S_REQ) && bus_ack && !bus_we) begin
      mem_data <= bus_rdata;
    end
  end

  assign busy      = (state != S_IDLE);
  assign bus_req   = (state == S_REQ);
  assign mem_valid = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign dbg_state = state;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed self-checking bench for lsu_bus_ctrl: one task per scenario,
// each comparing observed outputs against hand-computed values.
module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_req, st_req;
  logic [15:0] addr, st_data;
  logic        busy;
  logic [15:0] mem_data;
  logic        mem_valid, err;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int passed = 0;

  lsu_bus_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .ld_req(ld_req), .st_req(st_req), .addr(addr),
    .st_data(st_data), .busy(busy), .mem_data(mem_data), .mem_valid(mem_valid),
    .err(err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Transaction record filled by run_txn.
  int          r_busy, r_req, r_valid, r_err;
  logic        r_we, r_unstable;
  logic [15:0] r_addr, r_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it until busy drops. ack_at is the 0-based
  // REQ cycle in which bus_ack is driven (-1 = never). Returns in the first IDLE cycle.
  task automatic run_txn(input logic l, input logic s, input logic [15:0] a,
                         input logic [15:0] d, input int ack_at, input logic [15:0] rd);
    int n;
    r_busy = 0; r_req = 0; r_valid = 0; r_err = 0; r_unstable = 1'b0;
    r_we = 1'bx; r_addr = 16'hxxxx; r_wdata = 16'hxxxx;
    ld_req = l; st_req = s; addr = a; st_data = d;
    tick();
    ld_req = 1'b0; st_req = 1'b0; addr = 16'hFFFF; st_data = 16'hFFFF;
    n = 0;
    while (busy && n < 40) begin
      r_busy++;
      if (mem_valid) r_valid++;
      if (err) r_err++;
      if (bus_req) begin
        if (r_req == 0) begin
          r_we = bus_we; r_addr = bus_addr; r_wdata = bus_wdata;
        end else if (bus_we !== r_we || bus_addr !== r_addr || bus_wdata !== r_wdata) begin
          r_unstable = 1'b1;
        end
        if (r_req == ack_at) begin
          bus_ack = 1'b1; bus_rdata = rd;
        end
        r_req++;
      end
      tick();
      bus_ack = 1'b0; bus_rdata = 16'h0BAD;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, mem_valid, err, bus_req, bus_we} !== 5'b0 || mem_data !== 16'h0 ||
        bus_addr !== 16'h0 || bus_wdata !== 16'h0 || dbg_state !== 2'd0)
      $display("FAIL reset_values: busy=%b valid=%b err=%b req=%b we=%b mem_data=%h addr=%h wdata=%h state=%0d, required all zero",
               busy, mem_valid, err, bus_req, bus_we, mem_data, bus_addr, bus_wdata, dbg_state);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load();
    run_txn(1'b1, 1'b0, 16'h0040, 16'h7777, 3, 16'hBEEF);
    checks++;
    if (r_we !== 1'b0 || r_addr !== 16'h0040 || r_unstable)
      $display("FAIL load_bus_fields: we=%b addr=%h unstable=%b, required we=0 addr=0040 stable", r_we, r_addr, r_unstable);
    else passed++;
    checks++;
    if (r_busy != 5 || r_req != 4 || r_valid != 1 || r_err != 0)
      $display("FAIL load_timing: busy=%0d req=%0d valid=%0d err=%0d, required 5 4 1 0", r_busy, r_req, r_valid, r_err);
    else passed++;
    checks++;
    if (mem_data !== 16'hBEEF || mem_valid !== 1'b0)
      $display("FAIL load_data: mem_data=%h valid=%b, required BEEF 0", mem_data, mem_valid);
    else passed++;
  endtask

  task automatic test_store();
    run_txn(1'b0, 1'b1, 16'h0010, 16'h1234, 0, 16'hCAFE);
    checks++;
    if (r_we !== 1'b1 || r_addr !== 16'h0010 || r_wdata !== 16'h1234)
      $display("FAIL store_bus_fields: we=%b addr=%h wdata=%h, required 1 0010 1234", r_we, r_addr, r_wdata);
    else passed++;
    checks++;
    if (r_busy != 2 || r_req != 1 || r_valid != 1 || r_err != 0)
      $display("FAIL store_min_latency: busy=%0d req=%0d valid=%0d err=%0d, required 2 1 1 0", r_busy, r_req, r_valid, r_err);
    else passed++;
    checks++;
    if (mem_data !== 16'hBEEF)
      $display("FAIL store_mem_data: mem_data=%h, required BEEF", mem_data);
    else passed++;
  endtask

  task automatic test_conflict();
    run_txn(1'b1, 1'b1, 16'h0020, 16'h5555, 1, 16'hA5A5);
    checks++;
    if (r_we !== 1'b0 || r_addr !== 16'h0020 || mem_data !== 16'hA5A5 || r_valid != 1 || r_err != 0)
      $display("FAIL conflict_load_wins: we=%b addr=%h mem_data=%h valid=%0d err=%0d, required 0 0020 A5A5 1 0",
               r_we, r_addr, mem_data, r_valid, r_err);
    else passed++;
  endtask

  task automatic test_spurious_ack();
    int bad = 0;
    for (int i = 0; i < 3; i++) begin
      bus_ack = 1'b1; bus_rdata = 16'h9999;
      tick();
      if (busy || bus_req || mem_valid || err || mem_data !== 16'hA5A5) bad++;
    end
    bus_ack = 1'b0;
    checks++;
    if (bad != 0)
      $display("FAIL spurious_ack_idle: %0d cycles with output change (busy=%b mem_data=%h), required 0",
               bad, busy, mem_data);
    else passed++;
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 16'h0300, 16'h0, -1, 16'h0);
    checks++;
    if (r_req != 15 || r_busy != 16 || r_err != 1 || r_valid != 0)
      $display("FAIL timeout: req=%0d busy=%0d err=%0d valid=%0d, required 15 16 1 0", r_req, r_busy, r_err, r_valid);
    else passed++;
    checks++;
    if (mem_data !== 16'hA5A5 || busy || err)
      $display("FAIL timeout_idle: mem_data=%h busy=%b err=%b, required A5A5 0 0", mem_data, busy, err);
    else passed++;
  endtask

  // Each run_txn starts in the IDLE cycle right after the previous DONE/ERR.
  task automatic test_back_to_back();
    run_txn(1'b0, 1'b1, 16'h0400, 16'h4444, 0, 16'h0);
    run_txn(1'b1, 1'b0, 16'h0500, 16'h0, 0, 16'h1111);
    checks++;
    if (r_busy != 2 || r_valid != 1 || r_addr !== 16'h0500 || mem_data !== 16'h1111)
      $display("FAIL back_to_back_done: busy=%0d valid=%0d addr=%h mem_data=%h, required 2 1 0500 1111",
               r_busy, r_valid, r_addr, mem_data);
    else passed++;
    run_txn(1'b1, 1'b0, 16'h0600, 16'h0, -1, 16'h0);
    run_txn(1'b1, 1'b0, 16'h0700, 16'h0, 2, 16'h2222);
    checks++;
    if (r_busy != 4 || r_valid != 1 || r_err != 0 || mem_data !== 16'h2222)
      $display("FAIL back_to_back_err: busy=%0d valid=%0d err=%0d mem_data=%h, required 4 1 0 2222",
               r_busy, r_valid, r_err, mem_data);
    else passed++;
  endtask

  task automatic test_boundary();
    run_txn(1'b1, 1'b0, 16'h0800, 16'h0, 14, 16'h3C3C);
    checks++;
    if (r_req != 15 || r_valid != 1 || r_err != 0 || mem_data !== 16'h3C3C)
      $display("FAIL ack_at_timeout: req=%0d valid=%0d err=%0d mem_data=%h, required 15 1 0 3C3C",
               r_req, r_valid, r_err, mem_data);
    else passed++;
  endtask

  task automatic test_reset_mid_req();
    ld_req = 1'b1; addr = 16'h0900;
    tick();
    ld_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus_req !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_async: bus_req=%b busy=%b, required 0 0", bus_req, busy);
    else passed++;
    tick();
    rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = 16'h7E7E;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (busy || mem_valid || mem_data !== 16'h0000)
      $display("FAIL reset_late_ack: busy=%b valid=%b mem_data=%h, required 0 0 0000", busy, mem_valid, mem_data);
    else passed++;
    run_txn(1'b1, 1'b0, 16'h0A00, 16'h0, 1, 16'h6161);
    checks++;
    if (r_busy != 3 || r_valid != 1 || r_err != 0 || mem_data !== 16'h6161)
      $display("FAIL reset_then_load: busy=%0d valid=%0d err=%0d mem_data=%h, required 3 1 0 6161",
               r_busy, r_valid, r_err, mem_data);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; ld_req = 1'b0; st_req = 1'b0; addr = 16'h0; st_data = 16'h0;
    bus_ack = 1'b0; bus_rdata = 16'h0BAD;
    test_reset();
    test_load();
    test_store();
    test_conflict();
    test_spurious_ack();
    test_timeout();
    test_back_to_back();
    test_boundary();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
